// File: rtl/leaf_seq_collector.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_seq_collector
//  Purpose  : Buffers 42-bit leaf result words and streams them out as ASCII
//             nucleotide characters with a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module leaf_seq_collector #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [41:0]              in_result,
    input  logic                     out_ready,
    input  logic                     clear_ovf,
    output logic                     out_valid,
    output logic [9:0]               out_addr,
    output logic [7:0]               out_char,
    output logic [3:0]               out_index,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              words_done
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_CNT = (c_AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    logic [41:0]     r_in_q;
    logic [41:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    state_t          r_state;
    logic [41:0]     r_work;
    logic [3:0]      r_index;
    logic            r_valid;
    logic            r_ovf;
    logic [15:0]     r_done;

    logic            w_new;
    logic            w_empty;
    logic            w_full;
    logic            w_fire;
    logic            w_word_end;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [1:0]      w_nt;

    // A held value is only a new word on its first cycle; zero means "no result".
    assign w_new      = (in_result != '0) && (in_result != r_in_q);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_CNT);
    assign w_fire     = r_valid && out_ready;
    assign w_word_end = w_fire && (r_index == 4'd15);
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_word_end);
    assign w_push     = w_new && (!w_full || w_pop);
    assign w_drop     = w_new && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_q <= '0;
        end else begin
            r_in_q <= in_result;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new overflow event takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clear_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_work  <= '0;
            r_index <= '0;
            r_done  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_work  <= r_mem[r_rptr];
                        r_index <= '0;
                        r_valid <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_fire) begin
                        r_index <= r_index + 1'b1;
                        if (r_index == 4'd15) begin
                            r_done <= r_done + 1'b1;
                            // Chain straight into the next word to avoid a bubble.
                            if (w_pop) begin
                                r_work  <= r_mem[r_rptr];
                                r_index <= '0;
                            end else begin
                                r_valid <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_nt = r_work[{r_index, 1'b0} +: 2];

    always_comb begin
        out_char = 8'h41;
        case (w_nt)
            2'b00:   out_char = 8'h41;
            2'b01:   out_char = 8'h43;
            2'b10:   out_char = 8'h47;
            default: out_char = 8'h54;
        endcase
    end

    assign out_valid  = r_valid;
    assign out_addr   = r_work[41:32];
    assign out_index  = r_index;
    assign out_last   = r_valid && (r_index == 4'd15);
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
    assign words_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_leaf_seq_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leaf_seq_collector
//  Purpose  : Scoreboard bench for leaf_seq_collector character streaming.
//  Revision : 1.0  initial release
// ============================================================================
module tb_leaf_seq_collector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [41:0] in_result;
    logic        out_ready;
    logic        clear_ovf;
    logic        out_valid;
    logic [9:0]  out_addr;
    logic [7:0]  out_char;
    logic [3:0]  out_index;
    logic        out_last;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [15:0] words_done;

    leaf_seq_collector #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_result  (in_result),
        .out_ready  (out_ready),
        .clear_ovf  (clear_ovf),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_char   (out_char),
        .out_index  (out_index),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    typedef logic [22:0] exp_t;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_stall = 1'b0;
    exp_t prev_out;

    function automatic logic [7:0] nt_char(input logic [1:0] nt);
        case (nt)
            2'b00:   return 8'h41;
            2'b01:   return 8'h43;
            2'b10:   return 8'h47;
            default: return 8'h54;
        endcase
    endfunction

    task automatic expect_word(input logic [41:0] w, input int nchars);
        for (int i = 0; i < nchars; i++) begin
            exp_q.push_back({w[41:32], nt_char(w[2*i +: 2]), 4'(i), (i == 15)});
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d chars outstanding expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {out_valid, out_addr, out_char, out_index, out_last, fifo_count, overflow, words_done},
              {1'b0, 10'd0, 8'h41, 4'd0, 1'b0, 4'd0, 1'b0, 16'd0});
    endtask

    // Monitor: compare every handshake against the scoreboard, and check stalls hold.
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = {out_addr, out_char, out_index, out_last};
        if (prev_stall && out_valid) begin
            n_tests++;
            if (cur !== prev_out) begin
                n_fail++;
                $display("FAIL stall_stable: got 0x%0h expected 0x%0h", cur, prev_out);
            end
        end
        if (out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_char: got 0x%0h expected no output", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_fail++;
                    $display("FAIL char_stream: got 0x%0h expected 0x%0h", cur, e);
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = cur;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] wa;
        logic [41:0] wb;
        logic [41:0] wx;
        logic [41:0] ws [10];
        int cnt;
        int first;
        int last;

        reset     = 1'b0;
        in_result = '0;
        out_ready = 1'b1;
        clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        @(posedge clk); #1 reset = 1'b1;

        // Held word is pushed once; E4 unpacks to A,C,G,T then twelve A.
        wa = {10'd5, 32'h0000_00E4};
        expect_word(wa, 16);
        @(posedge clk); #1 in_result = wa;
        repeat (4) @(posedge clk);
        #1 in_result = '0;
        drain("single_word", 60);
        check("single_words_done", words_done, 64'd1);
        check("single_idle", {out_valid, fifo_count}, 64'd0);

        // Back-to-back distinct words must stream without a gap.
        wa = {10'd7, 32'h1B1B_1B1B};
        wb = {10'd9, 32'hFFFF_0000};
        expect_word(wa, 16);
        expect_word(wb, 16);
        cnt = 0; first = -1; last = -1;
        fork
            begin
                @(posedge clk); #1 in_result = wa;
                @(posedge clk); #1 in_result = wb;
                @(posedge clk); #1 in_result = '0;
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        cnt++;
                        if (first < 0) first = i;
                        last = i;
                    end
                end
            end
        join
        check("no_bubble", {cnt[31:0], 32'(last - first + 1)}, {32'd32, 32'd32});
        drain("two_words", 20);
        check("two_words_done", words_done, 64'd3);

        // Ready pattern 1,0,0,1 stalls the stream; order and stability still hold.
        wa = {10'd3, 32'h9C3A_5E21};
        expect_word(wa, 16);
        fork
            begin
                @(posedge clk); #1 in_result = wa;
                @(posedge clk); #1 in_result = '0;
            end
            begin
                for (int i = 0; i < 64; i++) begin
                    @(posedge clk);
                    #1 out_ready = (i % 4 == 0) || (i % 4 == 3);
                end
                out_ready = 1'b1;
            end
        join
        drain("stall_word", 40);
        check("stall_words_done", words_done, 64'd4);

        // Overflow: one word in the unpacker, eight buffered, tenth dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ws[k] = {10'(100 + k), 32'(32'h0101_0101 * (k + 1) + 32'h0F)};
        end
        for (int k = 0; k < 9; k++) expect_word(ws[k], 16);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1 in_result = ws[k];
        end
        @(posedge clk); #1 in_result = '0;
        @(negedge clk);
        check("ovf_fifo_count", fifo_count, 64'd8);
        check("ovf_set", overflow, 64'd1);
        @(posedge clk); #1 clear_ovf = 1'b1;
        @(posedge clk); #1 clear_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("ovf_drain", 200);
        check("ovf_words_done", words_done, 64'd13);

        // Reset mid-word at index 7 with three words queued.
        out_ready = 1'b0;
        expect_word(ws[0], 7);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 in_result = ws[k];
        end
        @(posedge clk); #1 in_result = '0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("mid_index", out_index, 64'd7);
        check("mid_count", fifo_count, 64'd3);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset_values");
        @(posedge clk); #1 reset = 1'b1;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_quiet", {out_valid, fifo_count, words_done, 32'(exp_q.size())}, 64'd0);

        // X,0,X pushes X twice.
        wx = {10'h3FF, 32'hAAAA_5555};
        expect_word(wx, 16);
        expect_word(wx, 16);
        @(posedge clk); #1 in_result = wx;
        @(posedge clk); #1 in_result = '0;
        @(posedge clk); #1 in_result = wx;
        @(posedge clk); #1 in_result = '0;
        drain("repeat_word", 60);
        check("repeat_words_done", words_done, 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
